// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// byte-mask constants and the alignment check.
package lsu_pkg;

  localparam int WIDTH = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // funct3[1:0] encodes the access size for every legal code.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      2'b10:   return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] lane);
    case (funct3[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane[1:0] != 2'b00;
      2'b11:   return lane != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension,
// and the store merge that replaces only the masked byte lanes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [2:0]       lane,
  input  logic [WIDTH-1:0] rd_word,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] merged
);

  logic [5:0]       bit_shift;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] wdata_sh;
  logic [WIDTH-1:0] bit_mask;
  logic [7:0]       byte_mask;
  logic             zext;

  assign bit_shift = {lane, 3'b000};
  assign zext      = funct3[2];

  always_comb begin
    shifted   = rd_word >> bit_shift;
    load_data = shifted;
    case (funct3[1:0])
      2'b00:   load_data = {{56{shifted[7]  & ~zext}}, shifted[7:0]};
      2'b01:   load_data = {{48{shifted[15] & ~zext}}, shifted[15:0]};
      2'b10:   load_data = {{32{shifted[31] & ~zext}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    byte_mask = size_mask(funct3[1:0]) << lane;
    bit_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    wdata_sh = wdata << bit_shift;
    merged   = (rd_word & ~bit_mask) | (wdata_sh & bit_mask);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the 64-bit doubleword data memory: decodes a
// byte-addressed request, runs the memory access, and returns one response.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int ABITS = DEPTH + 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [ABITS-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             mem_wr_en_o,
  output logic [DEPTH-1:0] mem_addr_wr_o,
  output logic [WIDTH-1:0] mem_data_wr_o,
  output logic             mem_rd_en_o,
  output logic [DEPTH-1:0] mem_addr_rd_o,
  input  logic [WIDTH-1:0] mem_data_rd_i,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a valid response holds its payload until accepted, and ready never
  // depends on valid of the same channel.

  state_t           state_q, state_d;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [ABITS-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] merged_q;
  logic             err_q;

  logic             accept;
  logic             req_err;
  logic [DEPTH-1:0] index;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] merged;

  assign accept  = req_valid_i && req_ready_o;
  assign req_err = (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]) ||
                   misaligned(req_funct3_i, req_addr_i[2:0]);
  assign index   = addr_q[ABITS-1:3];

  lsu_lane_align u_align (
    .funct3    (f3_q),
    .lane      (addr_q[2:0]),
    .rd_word   (mem_data_rd_i),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    mem_wr_en_o   = 1'b0;
    mem_addr_wr_o = '0;
    mem_data_wr_o = '0;
    mem_rd_en_o   = 1'b0;
    mem_addr_rd_o = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (!we_q) begin
          mem_rd_en_o   = 1'b1;
          mem_addr_rd_o = index;
          state_d       = RESP;
        end else if (f3_q[1:0] == 2'b11) begin
          mem_wr_en_o   = 1'b1;
          mem_addr_wr_o = index;
          mem_data_wr_o = wdata_q;
          state_d       = RESP;
        end else begin
          // Sub-doubleword store: read the old word so untouched lanes survive.
          mem_rd_en_o   = 1'b1;
          mem_addr_rd_o = index;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        mem_wr_en_o   = 1'b1;
        mem_addr_wr_o = index;
        mem_data_wr_o = merged_q;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merged_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state_q == ACCESS && !we_q) rdata_q  <= load_data;
      if (state_q == ACCESS && we_q)  merged_q <= merged;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the write and read ports of the 64-bit doubleword data memory for the single-cycle core's MEM stage.
- Accepts byte-addressed RISC-V load/store requests: LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD.
- Handles sign and zero extension on loads, and read-modify-write for sub-doubleword stores.
- Reports misaligned and illegal accesses through an error flag on the response channel.

Parameters:
- WIDTH, 64, memory word width in bits; fixed at 64.
- DEPTH, 5, memory address bits; the memory holds 2**DEPTH doublewords.
- ABITS, DEPTH+3, byte-address width of request addresses.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RISC-V funct3 (size and signedness).
- req_addr_i  in  ABITS  byte address.
- req_wdata_i  in  64  store data, right-aligned.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  64  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or illegal access.
- mem_wr_en_o  out  1  memory write enable.
- mem_addr_wr_o  out  DEPTH  memory write address.
- mem_data_wr_o  out  64  memory write data.
- mem_rd_en_o  out  1  memory read enable.
- mem_addr_rd_o  out  DEPTH  memory read address.
- mem_data_rd_i  in  64  memory read data; combinational, same-cycle.

Behaviour:
- State machine states: IDLE, ACCESS, WRITE, RESP.
- Reset, asynchronous on rst_ni low:
  - state = IDLE.
  - All registers cleared.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
  - mem_wr_en_o = 0, mem_rd_en_o = 0.
  - All memory address and data outputs = 0.
  - Reset mid-operation abandons the request; no memory write is issued after reset asserts.
- req_ready_o = 1 only in IDLE.
- On accept, latch we, funct3, addr and wdata, then decode:
  - Misaligned: halfword with addr[0] != 0; word with addr[1:0] != 0; doubleword with addr[2:0] != 0.
  - Illegal: funct3 = 111; store with funct3[2] = 1.
  - Error cases go IDLE -> RESP with rsp_err_o = 1 and rsp_rdata_o = 0. Memory enables never assert.
  - Otherwise go to ACCESS.
- Word index is addr[ABITS-1:3]. Byte lane is addr[2:0], little-endian.
- ACCESS, load:
  - mem_rd_en_o = 1, mem_addr_rd_o = index.
  - Shift the lane down by 8*addr[2:0]; sign-extend (funct3[2] = 0) or zero-extend (funct3[2] = 1) to 64 bits.
  - Register the result into rsp_rdata_o; go to RESP.
- ACCESS, SD:
  - mem_wr_en_o = 1, mem_addr_wr_o = index, mem_data_wr_o = wdata; go to RESP.
- ACCESS, SB/SH/SW:
  - mem_rd_en_o = 1.
  - Merge wdata into the byte lanes under a byte mask of 0x01/0x03/0x0F shifted left by addr[2:0].
  - Register the merged word; go to WRITE.
- WRITE: mem_wr_en_o = 1 with the merged word at index; go to RESP.
- RESP:
  - rsp_valid_o = 1; hold rsp_rdata_o and rsp_err_o stable until rsp_ready_i.
  - On handshake, go to IDLE. rsp_valid_o deasserts the next cycle.
  - There is no back-to-back overlap; the next accept is earliest the cycle after the handshake.
- Latency from the accept edge to rsp_valid_o:
  - Load and SD: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Memory enables are asserted only in ACCESS or WRITE. mem_wr_en_o and mem_rd_en_o are never both 1.
- Memory outputs are combinational from state and latched registers. They are 0 when not enabled.
- The lane-merge logic must not alter bytes outside the mask.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams: F3_B=000, F3_H=001, F3_W=010, F3_D=011, F3_BU=100, F3_HU=101, F3_WU=110.
  - State encoding.
  - Mask constants.
- One natural sub-module: lsu_lane_align. It is purely combinational and contains:
  - Load extract and extension: funct3, addr[2:0], word -> 64-bit result.
  - Store merge: funct3, addr[2:0], old word, wdata -> merged word.

Test Plan:
- Memory word 3 = 0x8877665544332211; LB at addr 0x1F -> rsp_rdata = 0xFFFFFFFFFFFFFF88, err = 0, rsp_valid 2 cycles after accept.
- Same word, LHU at 0x1C -> 0x0000000000006655; LW at 0x1C -> 0xFFFFFFFF88776655; LD at 0x18 -> 0x8877665544332211.
- SH with wdata 0xABCD at 0x1A, then LD at 0x18 -> 0x88776655ABCD2211. Write strobe lasts exactly 1 cycle, in WRITE. Response comes 3 cycles after accept.
- SD 0x0123456789ABCDEF at 0x08 -> one write cycle in ACCESS, no read enable; LD at 0x08 returns the same value.
- LW at 0x1E and funct3 = 111 load -> rsp_err = 1, rsp_rdata = 0, rsp_valid 1 cycle after accept, both memory enables stay 0. SD at 0x0C -> err = 1 and memory unchanged.
- Response backpressure and reset:
  - Hold rsp_ready_i = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, and req_ready_o = 0.
  - Assert rst_ni low during WRITE of an SB -> outputs clear immediately and memory is unmodified.
